mem_bank_loader: RTL and testbench
==================================

MEM_BANK_LOADER -- requirements
Module: mem_bank_loader

Interface
REQ-001 Parameter NUM_BANKS, 4, number of byte-wide banks written in parallel; BUS_W SHALL equal 8*NUM_BANKS.
REQ-002 Parameter BANK_DEPTH, 2048, entries per bank; ADDR_W = clog2(BANK_DEPTH).
REQ-003 Parameter BUS_W, 32, host write-data width in bits.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 writedata  input  BUS_W  host data word.
REQ-007 wr_valid  input  1  host strobe; a word is accepted on a cycle with wr_valid=1 and wr_ready=1.
REQ-008 wr_ready  output  1  loader can accept a word this cycle.
REQ-009 control_reg  input  32  [1:0] mode (0 idle, 1 packed, 2 byte, 3 treated as idle); [15:4] base address (low ADDR_W bits used); [31:16] length in bank entries.
REQ-010 bank_we  output  NUM_BANKS  per-bank write enable.
REQ-011 bank_addr  output  ADDR_W  common bank address.
REQ-012 bank_wdata  output  BUS_W  byte lane k drives bank k.
REQ-013 busy, done, overflow  output  1 each  load active; load complete (held); sticky address wrap.
REQ-014 load_count  output  16  words accepted in the current load.

Function
REQ-015 FSM states IDLE, LOAD_PACKED, LOAD_BYTE, DONE; IDLE->LOAD_* when registered mode changes from 0 to 1 or 2; latches base and length at that edge.
REQ-016 wr_ready=1 only in LOAD_PACKED/LOAD_BYTE; wr_valid in IDLE/DONE ignored, no write issued.
REQ-017 Packed: accepted word writes all banks at base+idx; first (most significant) byte to bank 0; idx increments per word.
REQ-018 Byte: writedata[7:0] to bank sel only (one-hot bank_we); sel increments, wraps after NUM_BANKS-1 and then idx increments.
REQ-019 Bank write outputs registered: bank_we/addr/wdata valid exactly 1 cycle after acceptance, bank_we low otherwise.
REQ-020 Completion: last entry (idx=length-1, and sel=NUM_BANKS-1 in byte mode) accepted -> DONE next cycle; done=1, busy=0, wr_ready=0.
REQ-021 length=0: transition directly to DONE, no writes.
REQ-022 Address base+idx wraps modulo BANK_DEPTH; first wrap sets overflow, held until next load start.
REQ-023 mode returning to 0 in any state -> IDLE next cycle; mid-load abort issues no further writes, done stays 0, load_count retained.
REQ-024 Mode change between 1 and 2 mid-load ignored until mode returns to 0.
REQ-025 Accept and mode-to-0 on same cycle: the accepted word is written, then IDLE.

Reset
REQ-026 reset low: FSM IDLE; wr_ready, bank_we, bank_addr, bank_wdata, busy, done, overflow, load_count all 0, immediately, independent of clk.
REQ-027 Release of reset mid-host-transfer: no write issued until a fresh 0->nonzero mode edge.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: extra output checksum[7:0], XOR of all bytes written in current load, cleared at load start and reset, valid when done=1.
REQ-029 Macro undefined: no checksum port or logic; all other behaviour identical.

Structure
REQ-030 Package npu_mem_pkg holds mode encodings, FSM state type, control_reg field offsets/widths.
REQ-031 One sub-module, bank_wr_demux: combinational byte-lane/bank-select steering into registered bank outputs; addressing and FSM stay in mem_bank_loader.

Verification
REQ-032 Packed, base=0, length=224, 224 words 0x00010203+n -> bank0..3 hold 00,01,02,03(+n bytes) at addr n; done after last word+1 cycle.
REQ-033 Byte, base=1568, length=2, bytes 0x11..0x18 -> bank0..3 addr 1568 = 11..14, addr 1569 = 15..18; load_count=8.
REQ-034 Packed, base=2046, length=4 -> writes at 2046,2047,0,1; overflow=1.
REQ-035 Mode set to 0 after 3 of 10 packed words -> exactly 3 writes, done=0, FSM IDLE next cycle.
REQ-036 reset asserted during LOAD_BYTE -> all outputs 0 same cycle; wr_valid held high afterwards -> no writes until new mode edge.
REQ-037 LOADER_CHECKSUM_EN, byte mode, bytes 0xA5,0x5A,0xFF,0x00 -> checksum=0x00; bytes 0x01,0x02 in length... packed word 0x01020408 -> checksum=0x0F.

Source files
------------

// File: rtl/npu_mem_pkg.sv
// npu_mem_pkg: shared encodings for mem_bank_loader
// Holds host mode codes, the loader FSM state type and control_reg field layout.
package npu_mem_pkg;
  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_PACKED = 2'd1;
  localparam logic [1:0] MODE_BYTE   = 2'd2;
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_W   = 2;
  localparam int CTRL_BASE_LSB = 4;
  localparam int CTRL_BASE_W   = 12;
  localparam int CTRL_LEN_LSB  = 16;
  localparam int CTRL_LEN_W    = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD_PACKED, ST_LOAD_BYTE, ST_DONE} state_t;
  // Mode 3 is reserved and behaves like idle, so only 1 and 2 start a load.
  function automatic logic mode_is_load(input logic [1:0] m);
    return m == MODE_PACKED || m == MODE_BYTE;
  endfunction
endpackage

// File: rtl/bank_wr_demux.sv
// bank_wr_demux: steers an accepted host word onto the byte lanes and registers the bank write
// Ports: i_clk, i_rst_n (async active-low); i_accept word accepted this cycle;
//   i_byte_mode one-byte write to bank i_sel; i_addr bank address; i_data host word;
//   o_bank_we/o_bank_addr/o_bank_wdata registered bank write, lane k feeds bank k.
module bank_wr_demux #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 11,
  parameter int BUS_W     = 8 * NUM_BANKS,
  parameter int SEL_W     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_accept,
  input  logic                 i_byte_mode,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [BUS_W-1:0]     i_data,
  output logic [NUM_BANKS-1:0] o_bank_we,
  output logic [ADDR_W-1:0]    o_bank_addr,
  output logic [BUS_W-1:0]     o_bank_wdata
);
  logic [NUM_BANKS-1:0] w_we;
  logic [BUS_W-1:0]     w_wdata;
  // Packed words place their most significant byte on bank 0; byte mode broadcasts the low byte.
  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_lane
    assign w_wdata[8*k +: 8] = i_byte_mode ? i_data[7:0] : i_data[BUS_W-8-8*k +: 8];
    assign w_we[k] = i_accept && (!i_byte_mode || i_sel == SEL_W'(k));
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bank_we    <= '0;
      o_bank_addr  <= '0;
      o_bank_wdata <= '0;
    end else begin
      o_bank_we <= w_we;
      if (i_accept) begin
        o_bank_addr  <= i_addr;
        o_bank_wdata <= w_wdata;
      end
    end
  end
endmodule

// File: rtl/mem_bank_loader.sv
// mem_bank_loader: loads host words into NUM_BANKS byte-wide banks in packed or byte mode
// Ports: i_clk, i_rst_n (async active-low); i_writedata/i_wr_valid/o_wr_ready host handshake;
//   i_control_reg [1:0] mode, [15:4] base, [31:16] length; o_bank_we/o_bank_addr/o_bank_wdata
//   registered bank write; o_busy, o_done, o_overflow status; o_load_count accepted words.
// Optional: define LOADER_CHECKSUM_EN to add o_checksum, XOR of all bytes written this load.
module mem_bank_loader
  import npu_mem_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 2048,
  parameter int BUS_W      = 8 * NUM_BANKS,
  localparam int ADDR_W    = $clog2(BANK_DEPTH),
  localparam int SEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [BUS_W-1:0]     i_writedata,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [31:0]          i_control_reg,
  output logic [NUM_BANKS-1:0] o_bank_we,
  output logic [ADDR_W-1:0]    o_bank_addr,
  output logic [BUS_W-1:0]     o_bank_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [15:0]          o_load_count
`ifdef LOADER_CHECKSUM_EN
  , output logic [7:0]         o_checksum
`endif
);
  state_t            r_state, w_state_nx;
  logic              r_prev_idle, r_ovf;
  logic [ADDR_W-1:0] r_base;
  logic [15:0]       r_len, r_idx, r_count;
  logic [SEL_W-1:0]  r_sel;
  logic [1:0]        w_mode;
  logic [15:0]       w_len;
  logic              w_mode_idle, w_start, w_loading, w_byte, w_accept, w_sel_last, w_last, w_wrap;
  logic [31:0]       w_sum;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;
  assign w_unused    = ^i_control_reg;
  assign w_mode      = i_control_reg[CTRL_MODE_LSB +: CTRL_MODE_W];
  assign w_len       = i_control_reg[CTRL_LEN_LSB +: CTRL_LEN_W];
  assign w_mode_idle = !mode_is_load(w_mode);
  // r_prev_idle resets to 0 so a mode held nonzero across reset cannot start a load.
  assign w_start     = r_state == ST_IDLE && r_prev_idle && !w_mode_idle;
  assign w_loading   = r_state == ST_LOAD_PACKED || r_state == ST_LOAD_BYTE;
  assign w_byte      = r_state == ST_LOAD_BYTE;
  assign w_accept    = i_wr_valid && w_loading;
  assign w_sel_last  = r_sel == SEL_W'(NUM_BANKS - 1);
  assign w_last      = r_idx == r_len - 16'd1 && (!w_byte || w_sel_last);
  assign w_sum       = 32'(r_base) + 32'(r_idx);
  assign w_wrap      = w_sum >= 32'(BANK_DEPTH);
  assign w_addr      = ADDR_W'(w_sum % 32'(BANK_DEPTH));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = w_mode_idle ? ST_IDLE :
                 w_start ? (w_len == 16'd0 ? ST_DONE : w_mode == MODE_PACKED ? ST_LOAD_PACKED : ST_LOAD_BYTE) :
                 (w_accept && w_last) ? ST_DONE : r_state;
  end
  always_comb begin
    o_wr_ready = w_loading;
    o_busy     = w_loading;
    o_done     = r_state == ST_DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_idle <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_sel       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_prev_idle <= w_mode_idle;
      if (w_start) begin
        r_base  <= i_control_reg[CTRL_BASE_LSB +: ADDR_W];
        r_len   <= w_len;
        r_idx   <= '0;
        r_sel   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_accept) begin
        r_count <= r_count + 16'd1;
        r_ovf   <= r_ovf | w_wrap;
        r_idx   <= (!w_byte || w_sel_last) ? r_idx + 16'd1 : r_idx;
        r_sel   <= (!w_byte || w_sel_last) ? '0 : r_sel + SEL_W'(1);
      end
    end
  end
  assign o_overflow   = r_ovf;
  assign o_load_count = r_count;
  bank_wr_demux #(
    .NUM_BANKS(NUM_BANKS),
    .ADDR_W   (ADDR_W),
    .BUS_W    (BUS_W),
    .SEL_W    (SEL_W)
  ) u_demux (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_accept    (w_accept),
    .i_byte_mode (w_byte),
    .i_sel       (r_sel),
    .i_addr      (w_addr),
    .i_data      (i_writedata),
    .o_bank_we   (o_bank_we),
    .o_bank_addr (o_bank_addr),
    .o_bank_wdata(o_bank_wdata)
  );
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum, w_word_xor;
  always_comb begin
    w_word_xor = '0;
    for (int k = 0; k < NUM_BANKS; k++) w_word_xor = w_word_xor ^ i_writedata[8*k +: 8];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_accept) r_csum <= r_csum ^ (w_byte ? i_writedata[7:0] : w_word_xor);
  end
  assign o_checksum = r_csum;
`endif
endmodule

// File: tb/tb_mem_bank_loader.sv
// tb_mem_bank_loader: randomized scoreboard bench for mem_bank_loader
module tb_mem_bank_loader;
  localparam int NB = 4, DEPTH = 2048, BW = 32, AW = 11;
  logic clk = 0, rst_n = 0, wr_valid = 0;
  logic wr_ready, busy, done, ovf;
  logic [BW-1:0] wdata_in = '0, bank_wdata;
  logic [31:0] ctrl = '0;
  logic [NB-1:0] bank_we;
  logic [AW-1:0] bank_addr;
  logic [15:0] load_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif
  int total = 0, bad = 0;
  typedef struct packed {
    logic [NB-1:0] we;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic [BW-1:0] mask;
  } wr_t;
  wr_t sb[$];
  logic [31:0] dq[$];
  int m_phase = 0, m_base = 0, m_len = 0, m_n = 0, m_count = 0;
  bit m_prev_idle = 0, m_byte = 0, m_ovf = 0;
  logic [7:0] m_csum = '0;

  mem_bank_loader dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_writedata(wdata_in), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready), .i_control_reg(ctrl), .o_bank_we(bank_we),
    .o_bank_addr(bank_addr), .o_bank_wdata(bank_wdata), .o_busy(busy), .o_done(done),
    .o_overflow(ovf), .o_load_count(load_count)
`ifdef LOADER_CHECKSUM_EN
    , .o_checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(int mode, int base, int len);
    return {16'(len), 12'(base), 2'b00, 2'(mode)};
  endfunction

  // One clock of stimulus; the model decides from the load rules what this cycle must write.
  task automatic step(bit v, logic [31:0] d, logic [31:0] c);
    wr_t w;
    int e, a, lane;
    bit idle, acc;
    @(negedge clk);
    wr_valid = v;
    wdata_in = d;
    ctrl = c;
    idle = !(c[1:0] == 2'd1 || c[1:0] == 2'd2);
    if (rst_n) begin
      acc = v && m_phase == 1;
      if (acc) begin
        w = '0;
        e = m_byte ? m_n / NB : m_n;
        a = m_base + e;
        if (a >= DEPTH) m_ovf = 1;
        w.addr = AW'(a % DEPTH);
        if (m_byte) begin
          lane = m_n % NB;
          w.we = NB'(1) << lane;
          w.data = BW'(d[7:0]) << (8 * lane);
          w.mask = BW'(8'hFF) << (8 * lane);
          m_csum ^= d[7:0];
        end else begin
          w.we = '1;
          w.mask = '1;
          for (int k = 0; k < NB; k++) begin
            w.data[8*k +: 8] = 8'(d >> (8 * (NB - 1 - k)));
            m_csum ^= 8'(d >> (8 * k));
          end
        end
        sb.push_back(w);
        m_n++;
        m_count++;
      end
      if (idle) m_phase = 0;
      else if (m_phase == 0 && m_prev_idle) begin
        m_base = int'(c[14:4]);
        m_len = int'(c[31:16]);
        m_byte = c[1:0] == 2'd2;
        m_n = 0;
        m_count = 0;
        m_ovf = 0;
        m_csum = '0;
        m_phase = m_len == 0 ? 2 : 1;
      end else if (acc && m_n == (m_byte ? m_len * NB : m_len)) m_phase = 2;
      m_prev_idle = idle;
    end
    @(posedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, $urandom, 32'h0);
  endtask

  task automatic run_load(int mode, int feed_mode, int base, int len);
    logic [31:0] c0, c1;
    bit v;
    c0 = mk(mode, base, len);
    c1 = mk(feed_mode, base, len);
    step(0, $urandom, c0);
    while (m_phase == 1) begin
      v = $urandom_range(0, 3) != 0;
      step(v, (v && dq.size() != 0) ? dq[0] : $urandom, c1);
      if (v && dq.size() != 0) void'(dq.pop_front());
    end
    repeat (2) step(1, $urandom, c1);
  endtask

  task automatic fill_rand(int n);
    dq.delete();
    repeat (n) dq.push_back($urandom);
  endtask

  // Monitor: pops the expected bank write whenever one is due or the DUT issues one.
  initial forever begin
    wr_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0 || bank_we != 0) begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = '0;
      chk("bank_we", bank_we, e.we);
      if (e.we != 0) begin
        chk("bank_addr", bank_addr, e.addr);
        chk("bank_wdata", bank_wdata & e.mask, e.data);
      end
    end
    chk("wr_ready", wr_ready, m_phase == 1);
    chk("busy", busy, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("overflow", ovf, m_ovf);
    chk("load_count", load_count, 16'(m_count));
`ifdef LOADER_CHECKSUM_EN
    if (m_phase == 2) chk("checksum", checksum, m_csum);
`endif
  end

  initial begin
    step(0, 0, 0);
    #2;
    chk("rst_ready", wr_ready, 0);
    chk("rst_we", bank_we, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    idle(2);
    dq.delete();
    for (int n = 0; n < 224; n++) dq.push_back(32'h00010203 + 32'(n));
    run_load(1, 1, 0, 224);
    #2 chk("packed_count", load_count, 16'd224);
    idle(2);
    dq.delete();
    for (int n = 0; n < 8; n++) dq.push_back(32'h11 + 32'(n));
    run_load(2, 2, 1568, 2);
    #2 chk("byte_count", load_count, 16'd8);
    idle(2);
    fill_rand(4);
    run_load(1, 1, 2046, 4);
    #2 chk("wrap_ovf", ovf, 1'b1);
    idle(2);
    run_load(1, 1, 5, 0);
    #2 chk("len0_done", done, 1'b1);
    idle(2);
    step(0, 0, mk(1, 500, 10));
    repeat (3) step(1, $urandom, mk(1, 500, 10));
    step(0, 0, mk(0, 500, 10));
    #2;
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", load_count, 16'd3);
    step(1, $urandom, 0);
    step(0, 0, mk(1, 700, 10));
    repeat (2) step(1, $urandom, mk(1, 700, 10));
    step(1, $urandom, mk(3, 700, 10));
    #2 chk("accept_abort_count", load_count, 16'd3);
    idle(2);
    fill_rand(8);
    run_load(2, 1, 30, 2);
    idle(2);
    step(0, 0, mk(2, 100, 4));
    repeat (3) step(1, $urandom, mk(2, 100, 4));
    #2;
    rst_n = 0;
    m_phase = 0; m_prev_idle = 0; m_ovf = 0; m_count = 0; m_csum = '0;
    sb.delete();
    #1;
    chk("arst_we", bank_we, 0);
    chk("arst_addr", bank_addr, 0);
    chk("arst_wdata", bank_wdata, 0);
    chk("arst_ready", wr_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", load_count, 0);
    repeat (2) step(1, $urandom, mk(2, 100, 4));
    #2 rst_n = 1;
    repeat (4) step(1, $urandom, mk(2, 100, 4));
    idle(1);
    dq.delete();
    dq.push_back(32'hA5); dq.push_back(32'h5A); dq.push_back(32'hFF); dq.push_back(32'h00);
    run_load(2, 2, 40, 1);
`ifdef LOADER_CHECKSUM_EN
    #2 chk("csum_byte", checksum, 8'h00);
`endif
    idle(2);
    dq.delete();
    dq.push_back(32'h01020408);
    run_load(1, 1, 41, 1);
`ifdef LOADER_CHECKSUM_EN
    #2 chk("csum_packed", checksum, 8'h0F);
`endif
    idle(2);
    for (int i = 0; i < 10; i++) begin
      int md, ln;
      md = $urandom_range(1, 2);
      ln = $urandom_range(0, 6);
      fill_rand(ln * NB);
      run_load(md, $urandom_range(1, 2), $urandom_range(0, 4095), ln);
      idle(2);
    end
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
